fetch_prefetch: RTL and testbench

- Instruction-fetch stage of the single-issue RV32I core; sits directly upstream of decode.
- Owns the fetch PC and issues sequential requests to a synchronous instruction memory with 1-cycle read latency.
- Buffers returned words with their PCs in a small prefetch queue and presents the head to decode with a valid/ready handshake.
- Accepts redirects (branch/JAL/JALR) from decode via next_PC_select/target_PC and flushes stale work.

---
 rtl/core_pkg.sv | 27 ++
 rtl/fetch_fifo.sv | 52 +++++
 rtl/fetch_prefetch.sv | 97 +++++++++
 tb/tb_fetch_prefetch.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Definitions shared by the RV32I front end: address width default, opcode map
// and fetch constants used by both fetch and decode.
package core_pkg;

    localparam int DEFAULT_ADDRESS_BITS = 16;
    localparam int INSTR_BITS           = 32;
    localparam int PC_STEP              = 4;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

    typedef enum logic [6:0] {
        R_TYPE = 7'b0110011,
        I_TYPE = 7'b0010011,
        LOAD   = 7'b0000011,
        STORE  = 7'b0100011,
        BRANCH = 7'b1100011,
        JAL    = 7'b1101111,
        JALR   = 7'b1100111,
        LUI    = 7'b0110111,
        AUIPC  = 7'b0010111,
        SYSTEM = 7'b1110011
    } opcode_t;

    function automatic opcode_t opcode_of(input logic [31:0] instr);
        return opcode_t'(instr[6:0]);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding {pc, instruction} entries between fetch and decode.
// Head is read combinationally from the registered storage.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 48,
    localparam int PTR_BITS   = $clog2(DEPTH),
    localparam int COUNT_BITS = PTR_BITS + 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    input  logic                  clear,
    output logic [WIDTH-1:0]      head,
    output logic [COUNT_BITS-1:0] count
);

    logic [WIDTH-1:0]    mem [DEPTH];
    logic [PTR_BITS-1:0] wr_ptr;
    logic [PTR_BITS-1:0] rd_ptr;
    logic                do_push;
    logic                do_pop;

    // Clear dominates: a flushed cycle neither stores nor retires an entry.
    assign do_push = push & ~clear & (count != COUNT_BITS'(DEPTH));
    assign do_pop  = pop & ~clear & (count != '0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_BITS'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_BITS'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + COUNT_BITS'(1);
                2'b01:   count <= count - COUNT_BITS'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; count gates validity, so a reset
    // here would only add a wide reset fan-out for no functional gain.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_prefetch.sv
// Instruction-fetch stage: issues sequential reads, buffers returns, flushes on redirect.
// Optional counters are enabled with the FETCH_PREFETCH_STATS_EN macro.
module fetch_prefetch
    import core_pkg::*;
#(
    parameter int ADDRESS_BITS = DEFAULT_ADDRESS_BITS,
    parameter int DEPTH        = 4,
    parameter logic [ADDRESS_BITS-1:0] RESET_PC = '0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    next_PC_select,
    input  logic [ADDRESS_BITS-1:0] target_PC,
    output logic                    imem_req,
    output logic [ADDRESS_BITS-1:0] imem_addr,
    input  logic [31:0]             imem_rdata,
    output logic [ADDRESS_BITS-1:0] PC,
    output logic [31:0]             instruction,
    output logic                    out_valid,
    input  logic                    out_ready
`ifdef FETCH_PREFETCH_STATS_EN
    ,
    output logic [31:0]             stat_fetched,
    output logic [31:0]             stat_flushes
`endif
);

    localparam int COUNT_BITS = $clog2(DEPTH) + 1;
    localparam int ENTRY_BITS = ADDRESS_BITS + INSTR_BITS;

    logic [ADDRESS_BITS-1:0] fetch_pc;
    logic [ADDRESS_BITS-1:0] addr_d1;
    logic [ADDRESS_BITS-1:0] target_aligned;
    logic                    inflight;
    logic                    issue;
    logic                    push;
    logic                    pop;
    logic                    redirect;
    logic [COUNT_BITS-1:0]   count;
    logic [ENTRY_BITS-1:0]   head;

    assign out_valid      = (count != '0);
    assign pop            = out_valid & out_ready;
    assign redirect       = next_PC_select & pop;
    assign target_aligned = target_PC & ~ADDRESS_BITS'(3);

    // Entries in the queue plus the one word in flight must never exceed DEPTH.
    assign issue = ~reset & start & ~redirect &
                   ((int'(count) + int'(inflight)) < DEPTH);
    assign push  = inflight & ~redirect;

    assign imem_req  = issue;
    assign imem_addr = fetch_pc;

    assign {PC, instruction} = out_valid ? head : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            addr_d1  <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) addr_d1 <= fetch_pc;
            if (redirect)   fetch_pc <= target_aligned;
            else if (issue) fetch_pc <= fetch_pc + ADDRESS_BITS'(PC_STEP);
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_BITS)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data ({addr_d1, imem_rdata}),
        .pop       (pop),
        .clear     (redirect),
        .head      (head),
        .count     (count)
    );

`ifdef FETCH_PREFETCH_STATS_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            stat_fetched <= '0;
            stat_flushes <= '0;
        end else begin
            if (pop)      stat_fetched <= stat_fetched + 32'd1;
            if (redirect) stat_flushes <= stat_flushes + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_prefetch.sv
// Bench for fetch_prefetch: cycle table, scoreboard of issued PCs, and
// hand sequences for reset, start=0 drain and address wrap.
module tb_fetch_prefetch;

    localparam int AB    = 16;
    localparam int DEPTH = 4;

    logic          clock = 1'b0;
    logic          reset, start, next_PC_select, out_ready;
    logic [AB-1:0] target_PC;
    logic          imem_req, out_valid;
    logic [AB-1:0] imem_addr, PC;
    logic [31:0]   imem_rdata, instruction;

    logic          w_reset;
    logic          w_req, w_valid;
    logic [AB-1:0] w_addr, w_pc;
    logic [31:0]   w_rdata, w_instr;

`ifdef FETCH_PREFETCH_STATS_EN
    logic [31:0] stat_fetched, stat_flushes, w_fetched, w_flushes;
`endif

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always #5 clock = ~clock;

    fetch_prefetch #(.ADDRESS_BITS(AB), .DEPTH(DEPTH), .RESET_PC(16'h0000)) u_dut (
        .clock(clock), .reset(reset), .start(start),
        .next_PC_select(next_PC_select), .target_PC(target_PC),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .PC(PC), .instruction(instruction), .out_valid(out_valid), .out_ready(out_ready)
`ifdef FETCH_PREFETCH_STATS_EN
        , .stat_fetched(stat_fetched), .stat_flushes(stat_flushes)
`endif
    );

    fetch_prefetch #(.ADDRESS_BITS(AB), .DEPTH(DEPTH), .RESET_PC(16'hFFF8)) u_wrap (
        .clock(clock), .reset(w_reset), .start(1'b1),
        .next_PC_select(1'b0), .target_PC(16'h0000),
        .imem_req(w_req), .imem_addr(w_addr), .imem_rdata(w_rdata),
        .PC(w_pc), .instruction(w_instr), .out_valid(w_valid), .out_ready(1'b1)
`ifdef FETCH_PREFETCH_STATS_EN
        , .stat_fetched(w_fetched), .stat_flushes(w_flushes)
`endif
    );

    function automatic logic [31:0] tag(input logic [AB-1:0] a);
        return {~a, a};
    endfunction

    // Synchronous instruction memories: address-tagged words, garbage when idle.
    always @(posedge clock) begin
        imem_rdata <= imem_req ? tag(imem_addr) : 32'hBAD0_BAD0;
        w_rdata    <= w_req ? tag(w_addr) : 32'hBAD0_BAD0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: every issue predicted by the model enqueues its PC; pops compare.
    typedef struct {
        logic [AB-1:0] pc;
        int            avail;
    } pend_t;

    pend_t         sb[$];
    logic [AB-1:0] exp_fpc = 16'h0000;
    int            exp_pops = 0;
    int            exp_flushes = 0;

    always @(negedge clock) begin
        logic exp_valid, red, exp_req;
        #4;
        cyc++;
        if (reset) begin
            check("reset_req", 32'(imem_req), 32'd0);
            sb.delete();
            exp_fpc     = 16'h0000;
            exp_pops    = 0;
            exp_flushes = 0;
        end else begin
            exp_valid = (sb.size() > 0) && (sb[0].avail <= cyc);
            check("sb_valid", 32'(out_valid), 32'(exp_valid));
            if (exp_valid) begin
                check("sb_pc", 32'(PC), 32'(sb[0].pc));
                check("sb_instr", instruction, tag(sb[0].pc));
            end else begin
                check("empty_pc", 32'(PC), 32'd0);
                check("empty_instr", instruction, 32'd0);
            end
            red     = next_PC_select & exp_valid & out_ready;
            exp_req = start & ~red & (sb.size() < DEPTH);
            check("sb_req", 32'(imem_req), 32'(exp_req));
            if (exp_valid && out_ready) begin
                void'(sb.pop_front());
                exp_pops++;
            end
            if (red) begin
                sb.delete();
                exp_fpc = target_PC & ~16'h0003;
                exp_flushes++;
            end else if (exp_req) begin
                check("sb_addr", 32'(imem_addr), 32'(exp_fpc));
                sb.push_back('{pc: exp_fpc, avail: cyc + 2});
                exp_fpc = exp_fpc + 16'd4;
            end
            check("count_bound", 32'(u_dut.count <= DEPTH), 32'd1);
        end
    end

    typedef struct {
        logic          start, ready, sel;
        logic [AB-1:0] target;
        logic          exp_req;
        logic [AB-1:0] exp_addr;
        logic          exp_valid;
        logic [AB-1:0] exp_pc;
    } vec_t;

    function automatic vec_t v(input logic s, input logic r, input logic sel,
                               input logic [AB-1:0] t, input logic rq,
                               input logic [AB-1:0] a, input logic vl,
                               input logic [AB-1:0] p);
        vec_t x;
        x.start = s; x.ready = r; x.sel = sel; x.target = t;
        x.exp_req = rq; x.exp_addr = a; x.exp_valid = vl; x.exp_pc = p;
        return x;
    endfunction

    initial begin
        vec_t          vecs [19];
        logic [AB-1:0] wrap_exp [4];
        logic [AB-1:0] w_addrs [4];
        logic [AB-1:0] w_pcs [4];
        int            na, np;

        // Stall for 10 cycles, drain, then redirect on head 0x0010 to 0x0102.
        vecs[0]  = v(1, 0, 0, 16'h0000, 1, 16'h0000, 0, 16'h0000);
        vecs[1]  = v(1, 0, 0, 16'h0000, 1, 16'h0004, 0, 16'h0000);
        vecs[2]  = v(1, 0, 0, 16'h0000, 1, 16'h0008, 1, 16'h0000);
        vecs[3]  = v(1, 0, 0, 16'h0000, 1, 16'h000C, 1, 16'h0000);
        for (int i = 4; i < 10; i++)
            vecs[i] = v(1, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0000);
        vecs[10] = v(1, 1, 0, 16'h0000, 0, 16'h0000, 1, 16'h0000);
        vecs[11] = v(1, 1, 0, 16'h0000, 1, 16'h0010, 1, 16'h0004);
        vecs[12] = v(1, 1, 0, 16'h0000, 1, 16'h0014, 1, 16'h0008);
        vecs[13] = v(1, 1, 0, 16'h0000, 1, 16'h0018, 1, 16'h000C);
        vecs[14] = v(1, 1, 1, 16'h0102, 0, 16'h0000, 1, 16'h0010);
        vecs[15] = v(1, 1, 0, 16'h0000, 1, 16'h0100, 0, 16'h0000);
        vecs[16] = v(1, 1, 0, 16'h0000, 1, 16'h0104, 0, 16'h0000);
        vecs[17] = v(1, 1, 0, 16'h0000, 1, 16'h0108, 1, 16'h0100);
        vecs[18] = v(1, 1, 0, 16'h0000, 1, 16'h010C, 1, 16'h0104);

        reset = 1'b1; w_reset = 1'b1; start = 1'b0;
        next_PC_select = 1'b0; target_PC = '0; out_ready = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 19; i++) begin
            start = vecs[i].start; out_ready = vecs[i].ready;
            next_PC_select = vecs[i].sel; target_PC = vecs[i].target;
            #2;
            check($sformatf("tbl%0d_req", i), 32'(imem_req), 32'(vecs[i].exp_req));
            if (vecs[i].exp_req)
                check($sformatf("tbl%0d_addr", i), 32'(imem_addr), 32'(vecs[i].exp_addr));
            check($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(vecs[i].exp_valid));
            check($sformatf("tbl%0d_pc", i), 32'(PC), 32'(vecs[i].exp_valid ? vecs[i].exp_pc : 16'h0000));
            @(negedge clock);
        end
        next_PC_select = 1'b0; target_PC = '0;

        // Reset mid-stream with three queued entries and one request in flight.
        reset = 1'b1; start = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0; start = 1'b1;
        repeat (4) @(negedge clock);
        #2 check("pre_reset_count", 32'(u_dut.count), 32'd3);
        reset = 1'b1;
        @(negedge clock);
        #2;
        check("mid_reset_valid", 32'(out_valid), 32'd0);
        check("mid_reset_req", 32'(imem_req), 32'd0);
        @(negedge clock);

        // One request in flight then start drops: that word alone is delivered.
        reset = 1'b0; start = 1'b1; out_ready = 1'b1;
        #2;
        check("restart_req", 32'(imem_req), 32'd1);
        check("restart_addr", 32'(imem_addr), 32'h0000);
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        #2;
        check("drain_valid", 32'(out_valid), 32'd1);
        check("drain_pc", 32'(PC), 32'h0000);
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            #2;
            check("idle_valid", 32'(out_valid), 32'd0);
            check("idle_req", 32'(imem_req), 32'd0);
        end
        @(negedge clock);

        // Address wrap on the second instance, bounded to 12 cycles.
        wrap_exp[0] = 16'hFFF8; wrap_exp[1] = 16'hFFFC;
        wrap_exp[2] = 16'h0000; wrap_exp[3] = 16'h0004;
        for (int k = 0; k < 4; k++) begin
            w_addrs[k] = 16'hDEAD;
            w_pcs[k]   = 16'hDEAD;
        end
        na = 0; np = 0;
        w_reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            #2;
            if (w_req && na < 4) begin
                w_addrs[na] = w_addr;
                na++;
            end
            if (w_valid && np < 4) begin
                w_pcs[np] = w_pc;
                check("wrap_instr", w_instr, tag(w_pc));
                np++;
            end
            @(negedge clock);
        end
        check("wrap_pops_seen", 32'(np), 32'd4);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("wrap_addr%0d", k), 32'(w_addrs[k]), 32'(wrap_exp[k]));
            check($sformatf("wrap_pc%0d", k), 32'(w_pcs[k]), 32'(wrap_exp[k]));
        end

`ifdef FETCH_PREFETCH_STATS_EN
        #2;
        check("stat_fetched", stat_fetched, 32'(exp_pops));
        check("stat_flushes", stat_flushes, 32'(exp_flushes));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
